// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller and its buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  localparam int WORD_BYTES         = 4;
  localparam int DEFAULT_IMEM_WORDS = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched {pc, instr} entries with flush; head is read combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     push_entry,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard against over/underflow even if the controller misbehaves.
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks the PC through imem, buffers fetched words
// for decode, and handles redirect, halt and out-of-range faults.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        out_of_range,
  output logic [15:0] fetch_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t     state, state_next;
  logic [29:0]      pc_word, pc_word_next;
  logic             oor_next;
  logic             push, pop, flush, full;
  logic             pc_in_range, redir_in_range;
  logic [CNT_W-1:0] count;
  fetch_entry_t     push_entry, head;
  logic             unused_redirect_bits;

  // PC is kept word-indexed; the byte offset of a redirect target is dropped.
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign imem_addr      = {pc_word, 2'b00};
  assign pc_in_range    = {2'b00, pc_word} < 32'(IMEM_WORDS);
  assign redir_in_range = {2'b00, redirect_pc[31:2]} < 32'(IMEM_WORDS);
  assign full           = (count == CNT_W'(FIFO_DEPTH));
  assign dec_valid      = (count != '0);
  assign pop            = dec_valid && dec_ready && !flush;
  assign push_entry     = '{pc: imem_addr, instr: imem_instr};
  assign dec_pc         = head.pc;
  assign dec_instr      = head.instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BOOT;
      pc_word      <= RESET_PC[31:2];
      out_of_range <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state        <= state_next;
      pc_word      <= pc_word_next;
      out_of_range <= oor_next;
      if (push) fetch_count <= fetch_count + 16'd1;
    end
  end

  always_comb begin
    state_next   = state;
    pc_word_next = pc_word;
    oor_next     = out_of_range;
    push         = 1'b0;
    flush        = 1'b0;
    if (state == BOOT) begin
      state_next = RUN;
    end else if (redirect_valid) begin
      flush        = 1'b1;
      pc_word_next = redirect_pc[31:2];
      if (state == FAULT && redir_in_range) begin
        state_next = RUN;
        oor_next   = 1'b0;
      end
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state_next = HALTED;
          end else if (!pc_in_range) begin
            state_next = FAULT;
            oor_next   = 1'b1;
          end else if (!full) begin
            push         = 1'b1;
            pc_word_next = pc_word + 30'd1;
          end
        end
        HALTED:  if (!halt) state_next = RUN;
        default: ;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_fetch_ctrl;

  localparam int DEPTH = 2;
  localparam int WORDS = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        out_of_range;
  logic [15:0] fetch_count;
  logic [31:0] salt;

  always #5 clk = ~clk;

  // Instruction memory: word k holds k, optionally scrambled by a salt.
  assign imem_instr = {2'b00, imem_addr[31:2]} ^ salt;

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .out_of_range   (out_of_range),
    .fetch_count    (fetch_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Model: mode 0 = just reset, 1 = fetching, 2 = halted, 3 = faulted.
  ent_t        q[$];
  logic [31:0] m_pc;
  int          m_mode;
  logic        m_oor;
  logic [15:0] m_fc;
  int          errors = 0;
  int          checks = 0;

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> 2) < WORDS;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit   do_pop;
    bit   do_push;
    ent_t e;
    do_push = 1'b0;
    if (reset) begin
      q.delete();
      m_pc   = 32'h0;
      m_mode = 0;
      m_oor  = 1'b0;
      m_fc   = '0;
    end else begin
      do_pop = (q.size() != 0) && dec_ready;
      if (m_mode != 0 && redirect_valid) begin
        q.delete();
        m_pc = redirect_pc & ~32'h3;
        if (m_mode == 3 && in_rng(redirect_pc)) begin
          m_mode = 1;
          m_oor  = 1'b0;
        end
      end else begin
        case (m_mode)
          0: m_mode = 1;
          1: begin
            if (halt) m_mode = 2;
            else if (!in_rng(m_pc)) begin
              m_mode = 3;
              m_oor  = 1'b1;
            end else if (q.size() < DEPTH) do_push = 1'b1;
          end
          2: if (!halt) m_mode = 1;
          default: ;
        endcase
        e = '{pc: m_pc, instr: (m_pc >> 2) ^ salt};
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          q.push_back(e);
          m_pc = m_pc + 32'd4;
          m_fc = m_fc + 16'd1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("dec_valid", 32'(dec_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("dec_pc", dec_pc, q[0].pc);
      check("dec_instr", dec_instr, q[0].instr);
    end
    check("imem_addr", imem_addr, m_pc);
    check("out_of_range", 32'(out_of_range), 32'(m_oor));
    check("fetch_count", 32'(fetch_count), 32'(m_fc));
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic h, input logic rdy, input int n);
    reset          = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    dec_ready      = rdy;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    salt = 32'h0;
    q.delete();
    m_pc = 32'h0; m_mode = 0; m_oor = 1'b0; m_fc = '0;

    // Reset, then free fetch with decode always ready.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 6);

    // Decode stalled: buffer fills, PC holds; then drain in order.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 6);
    check("stall_fetch_count", 32'(fetch_count), 32'd2);
    check("stall_pc", imem_addr, 32'h8);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4);

    // Redirect to an unaligned target while the buffer is full.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 32'h23, 1'b0, 1'b0, 1);
    check("redir_pc", imem_addr, 32'h20);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3);

    // Run off the end of imem into FAULT, then recover by redirect.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 60);
    check("fault_flag", 32'(out_of_range), 32'd1);
    drive(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2);
    drive(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1);
    check("fault_cleared", 32'(out_of_range), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3);

    // Halt with a full buffer, redirect while halted, then resume.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    check("halt_pc", imem_addr, 32'h40);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4);

    // Reset in the middle of a stalled stream.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    check("rst_valid", 32'(dec_valid), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3);

    // Random traffic.
    halt = 1'b0;
    for (int i = 0; i < 500; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 32'h13f));
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      dec_ready      = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) salt = 32'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 64, meaning the number of instruction-memory words addressable.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address fetched first after reset.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of fetched-instruction buffer entries.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 imem_addr  output  32  byte address presented to the asynchronous instruction memory.
REQ-007 imem_instr  input  32  word returned combinationally for imem_addr.
REQ-008 redirect_valid  input  1  branch/exception redirect request.
REQ-009 redirect_pc  input  32  redirect target byte address.
REQ-010 halt  input  1  stop issuing new fetches while high.
REQ-011 dec_valid  output  1  buffer head holds a valid instruction.
REQ-012 dec_ready  input  1  decode stage accepts the head this cycle.
REQ-013 dec_instr  output  32  instruction at buffer head.
REQ-014 dec_pc  output  32  byte address of dec_instr.
REQ-015 out_of_range  output  1  sticky fault: PC beyond IMEM_WORDS.
REQ-016 fetch_count  output  16  number of instructions pushed since reset, wraps at 2^16.

Function
REQ-017 SHALL drive imem_addr combinationally from the PC register, with bits [1:0] always 0.
REQ-018 SHALL implement states BOOT, RUN, HALTED, FAULT.
REQ-019 BOOT: exactly one cycle after reset; no push; next state RUN.
REQ-020 RUN: push {pc, imem_instr} and set pc <= pc+4 when the pre-pop buffer count < FIFO_DEPTH and pc[31:2] < IMEM_WORDS.
REQ-021 RUN with a full buffer: no push, pc held, even if a pop occurs in the same cycle.
REQ-022 RUN with pc[31:2] >= IMEM_WORDS: no push; next state FAULT; out_of_range <= 1.
REQ-023 FAULT: no push; out_of_range stays 1; a redirect to an in-range address clears out_of_range and returns to RUN; an out-of-range redirect stays in FAULT.
REQ-024 halt=1 in RUN -> HALTED next cycle with no push that cycle; halt=0 in HALTED -> RUN; the buffer continues draining while HALTED.
REQ-025 Priority, highest first: reset, redirect, halt, range check, fetch.
REQ-026 Redirect (any state except BOOT): pc <= {redirect_pc[31:2], 2'b00}; buffer flushed to count 0; no push that cycle; dec_valid = 0 the following cycle.
REQ-027 A redirect while HALTED updates pc and flushes, but the state stays HALTED.
REQ-028 dec_valid = (count != 0); a pop occurs when dec_valid && dec_ready; dec_instr/dec_pc are stable while dec_valid && !dec_ready.
REQ-029 Push and pop in the same cycle with a non-full buffer: count unchanged; order preserved (FIFO).
REQ-030 fetch_count increments by 1 per push, wrapping 16'hFFFF -> 16'h0000.
REQ-031 Fetch-to-decode latency: an instruction pushed at edge N is visible on dec_instr after edge N when the buffer was empty.

Reset
REQ-032 On reset=1 at a clock edge: pc <= RESET_PC, state <= BOOT, count <= 0, fetch_count <= 0, out_of_range <= 0.
REQ-033 Reset mid-operation discards all buffered entries and any pending redirect; dec_valid = 0 in the cycle after reset.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enum (BOOT, RUN, HALTED, FAULT), WORD_BYTES = 4 and the default IMEM_WORDS.
REQ-035 Buffer SHALL be sub-module fetch_fifo (FIFO_DEPTH entries of {pc, instr}, push/pop/flush, count, with registered storage and combinational head).

Verification
REQ-036 Reset, dec_ready=1, imem word k = k -> BOOT 1 cycle, then dec_pc 0x0,0x4,0x8... with dec_instr 0,1,2 on consecutive cycles.
REQ-037 dec_ready=0 for 5 cycles -> exactly 2 pushes, pc=0x8 held, fetch_count=2; releasing dec_ready -> entries 0x0,0x4 delivered in order.
REQ-038 redirect_valid=1, redirect_pc=0x23 with a full buffer -> next cycle dec_valid=0, pc=0x20, then dec_pc=0x20.
REQ-039 Free-run to pc=0x100 (IMEM_WORDS=64) -> out_of_range=1, state FAULT, no further pushes; redirect to 0x10 -> RUN, out_of_range=0.
REQ-040 halt=1 for 3 cycles with 2 entries buffered -> both drain, no new pushes, redirect to 0x40 during halt keeps HALTED; halt=0 -> fetch resumes at 0x40.
REQ-041 Assert reset mid-stream with buffered entries -> next cycle dec_valid=0, fetch_count=0, imem_addr=RESET_PC.
